lsnn_synapse_integrator: RTL and testbench

Upstream stage of the LSNN neuron. It converts N_IN binary presynaptic spike lines into the 8-bit input current that drives the neuron's current input. Each active spike adds a programmable per-channel weight to a leaky current trace, which decays by a right shift every cycle. A small FSM separates weight configuration, running, and a drain-to-zero flush.

---
 rtl/lsnn_pkg.sv | 20 ++
 rtl/lsnn_weight_bank.sv | 33 +++
 rtl/lsnn_synapse_integrator.sv | 94 +++++++++
 tb/tb_lsnn_synapse_integrator.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsnn_pkg.sv
// Shared types and helpers for the LSNN synapse integrator.
package lsnn_pkg;

    localparam int CUR_W_DEF = 8;
    localparam logic [7:0] DEFAULT_WEIGHT_DEF = 8'h08;

    typedef enum logic [1:0] {
        ST_CFG   = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } state_e;

    // Clips an unsigned sum to the largest value representable in 'width' bits.
    function automatic logic [31:0] sat_add(input logic [31:0] sum, input int unsigned width);
        logic [31:0] max_v;
        max_v = (32'd1 << width) - 32'd1;
        return (sum > max_v) ? max_v : sum;
    endfunction

endpackage

// File: rtl/lsnn_weight_bank.sv
// Per-channel synaptic weight register file with flat combinational read.
module lsnn_weight_bank
    import lsnn_pkg::*;
#(
    parameter int N_IN = 4,
    parameter int CUR_W = CUR_W_DEF,
    parameter logic [CUR_W-1:0] DEFAULT_WEIGHT = CUR_W'(DEFAULT_WEIGHT_DEF)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [$clog2(N_IN)-1:0]  wr_idx,
    input  logic [CUR_W-1:0]         wr_data,
    output logic [N_IN*CUR_W-1:0]    weights
);

    logic [CUR_W-1:0] wt_q [N_IN];

    always_ff @(posedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < N_IN; i++) begin
                wt_q[i] <= DEFAULT_WEIGHT;
            end
        end else if (wr_en) begin
            wt_q[wr_idx] <= wr_data;
        end
    end

    for (genvar g = 0; g < N_IN; g++) begin : g_rd
        assign weights[g*CUR_W +: CUR_W] = wt_q[g];
    end

endmodule

// File: rtl/lsnn_synapse_integrator.sv
// Spike-gated weight accumulation into a leaky, saturating current trace.
module lsnn_synapse_integrator
    import lsnn_pkg::*;
#(
    parameter int N_IN = 4,
    parameter int CUR_W = CUR_W_DEF,
    parameter int DECAY_SHIFT = 1,
    parameter logic [CUR_W-1:0] DEFAULT_WEIGHT = CUR_W'(DEFAULT_WEIGHT_DEF)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_IN-1:0]          spike_in,
    input  logic                     start,
    input  logic                     stop,
    input  logic                     wt_valid,
    input  logic [$clog2(N_IN)-1:0]  wt_idx,
    input  logic [CUR_W-1:0]         wt_data,
    output logic                     wt_ready,
    output logic [CUR_W-1:0]         current_out,
    output logic                     sat_flag,
    output logic [1:0]               mode
);

    // Wide enough to hold the decayed trace plus every weight without wrapping.
    localparam int SUM_W = CUR_W + $clog2(N_IN + 1);

    state_e               state, state_next;
    logic [CUR_W-1:0]     trace, trace_next;
    logic                 sat_next;
    logic [SUM_W-1:0]     sum;
    logic [N_IN*CUR_W-1:0] weights;
    logic                 wr_en;

    assign wt_ready    = (state == ST_CFG);
    assign wr_en       = wt_valid && wt_ready && (int'(wt_idx) < N_IN);
    assign current_out = trace;
    assign mode        = state;

    lsnn_weight_bank #(
        .N_IN           (N_IN),
        .CUR_W          (CUR_W),
        .DEFAULT_WEIGHT (DEFAULT_WEIGHT)
    ) u_bank (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_en),
        .wr_idx  (wt_idx),
        .wr_data (wt_data),
        .weights (weights)
    );

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state    <= ST_CFG;
            trace    <= '0;
            sat_flag <= 1'b0;
        end else begin
            state    <= state_next;
            trace    <= trace_next;
            sat_flag <= sat_next;
        end
    end

    always_comb begin
        state_next = ST_CFG;
        trace_next = '0;
        sat_next   = 1'b0;
        sum        = SUM_W'(trace >> DECAY_SHIFT);
        for (int i = 0; i < N_IN; i++) begin
            if (spike_in[i]) begin
                sum = sum + SUM_W'(weights[i*CUR_W +: CUR_W]);
            end
        end
        case (state)
            ST_CFG: begin
                state_next = start ? ST_RUN : ST_CFG;
            end
            ST_RUN: begin
                trace_next = CUR_W'(sat_add(32'(sum), CUR_W));
                sat_next   = (32'(sum) != 32'(trace_next));
                state_next = stop ? ST_FLUSH : ST_RUN;
            end
            ST_FLUSH: begin
                trace_next = trace >> DECAY_SHIFT;
                state_next = (trace == '0) ? ST_CFG : ST_FLUSH;
            end
            default: begin
                state_next = ST_CFG;
                trace_next = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_lsnn_synapse_integrator.sv
// Directed self-checking bench for lsnn_synapse_integrator.
module tb_lsnn_synapse_integrator;

    logic       clk;
    logic       rst_n;
    logic [3:0] spike_in;
    logic       start;
    logic       stop;
    logic       wt_valid;
    logic [1:0] wt_idx;
    logic [7:0] wt_data;
    logic       wt_ready;
    logic [7:0] current_out;
    logic       sat_flag;
    logic [1:0] mode;

    int checks = 0;
    int failures = 0;

    lsnn_synapse_integrator dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .spike_in    (spike_in),
        .start       (start),
        .stop        (stop),
        .wt_valid    (wt_valid),
        .wt_idx      (wt_idx),
        .wt_data     (wt_data),
        .wt_ready    (wt_ready),
        .current_out (current_out),
        .sat_flag    (sat_flag),
        .mode        (mode)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b1;
        spike_in = 4'b0;
        start = 1'b0;
        stop = 1'b0;
        wt_valid = 1'b0;
        wt_idx = 2'd0;
        wt_data = 8'd0;
        step();
        step();
        rst_n = 1'b0;
    endtask

    task automatic write_w(input logic [1:0] idx, input logic [7:0] data);
        wt_valid = 1'b1;
        wt_idx = idx;
        wt_data = data;
        checks++;
        if (wt_ready !== 1'b1) begin
            failures++;
            $display("FAIL write_ready idx=%0d wt_ready=%b expected=1", idx, wt_ready);
        end
        step();
        wt_valid = 1'b0;
    endtask

    task automatic go_run();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic go_cfg();
        bit done;
        done = 1'b0;
        spike_in = 4'b0;
        stop = 1'b1;
        step();
        stop = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (mode == 2'd0) begin
                done = 1'b1;
                break;
            end
            step();
        end
        checks++;
        if (!done) begin
            failures++;
            $display("FAIL flush_timeout mode=%0d expected=0", mode);
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (current_out !== 8'd0) begin
            failures++;
            $display("FAIL reset_current current_out=%0d expected=0", current_out);
        end
        checks++;
        if (wt_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_ready wt_ready=%b expected=1", wt_ready);
        end
        checks++;
        if (mode !== 2'd0) begin
            failures++;
            $display("FAIL reset_mode mode=%0d expected=0", mode);
        end
        checks++;
        if (sat_flag !== 1'b0) begin
            failures++;
            $display("FAIL reset_sat sat_flag=%b expected=0", sat_flag);
        end
        spike_in = 4'b1111;
        step();
        checks++;
        if (current_out !== 8'd0) begin
            failures++;
            $display("FAIL cfg_ignores_spikes current_out=%0d expected=0", current_out);
        end
        spike_in = 4'b0;
        go_run();
        checks++;
        if (mode !== 2'd1 || current_out !== 8'd0) begin
            failures++;
            $display("FAIL run_entry mode=%0d current_out=%0d expected mode=1 current_out=0", mode, current_out);
        end
        spike_in = 4'b0001;
        step();
        checks++;
        if (current_out !== 8'd8) begin
            failures++;
            $display("FAIL reset_default_weight current_out=%0d expected=8", current_out);
        end
        go_cfg();
    endtask

    task automatic test_decay();
        int exp_d[8] = '{32, 16, 8, 4, 2, 1, 0, 0};
        go_run();
        spike_in = 4'b1111;
        for (int i = 0; i < 8; i++) begin
            step();
            spike_in = 4'b0;
            checks++;
            if (current_out !== 8'(exp_d[i])) begin
                failures++;
                $display("FAIL decay[%0d] current_out=%0d expected=%0d", i, current_out, exp_d[i]);
            end
        end
        go_cfg();
    endtask

    task automatic test_steady();
        int exp_s[9] = '{20, 30, 35, 37, 38, 39, 39, 39, 39};
        // Write and start in the same cycle: new weight must be used at once.
        wt_valid = 1'b1;
        wt_idx = 2'd0;
        wt_data = 8'd20;
        start = 1'b1;
        step();
        wt_valid = 1'b0;
        start = 1'b0;
        spike_in = 4'b0001;
        for (int i = 0; i < 9; i++) begin
            step();
            checks++;
            if (current_out !== 8'(exp_s[i]) || sat_flag !== 1'b0) begin
                failures++;
                $display("FAIL steady[%0d] current_out=%0d sat_flag=%b expected=%0d sat=0", i, current_out, sat_flag, exp_s[i]);
            end
        end
        go_cfg();
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 4; i++) write_w(2'(i), 8'hC8);
        go_run();
        spike_in = 4'b1111;
        step();
        checks++;
        if (current_out !== 8'd255 || sat_flag !== 1'b1) begin
            failures++;
            $display("FAIL sat_all current_out=%0d sat_flag=%b expected=255 sat=1", current_out, sat_flag);
        end
        spike_in = 4'b0;
        step();
        checks++;
        if (current_out !== 8'd127 || sat_flag !== 1'b0) begin
            failures++;
            $display("FAIL sat_release current_out=%0d sat_flag=%b expected=127 sat=0", current_out, sat_flag);
        end
        spike_in = 4'b0001;
        step();
        checks++;
        if (current_out !== 8'd255 || sat_flag !== 1'b1) begin
            failures++;
            $display("FAIL sat_edge current_out=%0d sat_flag=%b expected=255 sat=1", current_out, sat_flag);
        end
        go_cfg();
    endtask

    task automatic test_flush_simul();
        int exp_f[7] = '{50, 25, 12, 6, 3, 1, 0};
        go_run();
        spike_in = 4'b0001;
        step();
        checks++;
        if (current_out !== 8'd200) begin
            failures++;
            $display("FAIL flush_setup current_out=%0d expected=200", current_out);
        end
        spike_in = 4'b0;
        start = 1'b1;
        stop = 1'b1;
        step();
        start = 1'b0;
        stop = 1'b0;
        checks++;
        if (current_out !== 8'd100 || mode !== 2'd2) begin
            failures++;
            $display("FAIL flush_entry current_out=%0d mode=%0d expected=100 mode=2", current_out, mode);
        end
        spike_in = 4'b1111;
        start = 1'b1;
        for (int i = 0; i < 7; i++) begin
            step();
            checks++;
            if (current_out !== 8'(exp_f[i]) || mode !== 2'd2 || sat_flag !== 1'b0) begin
                failures++;
                $display("FAIL flush[%0d] current_out=%0d mode=%0d sat=%b expected=%0d mode=2 sat=0", i, current_out, mode, sat_flag, exp_f[i]);
            end
        end
        start = 1'b0;
        step();
        checks++;
        if (mode !== 2'd0 || current_out !== 8'd0) begin
            failures++;
            $display("FAIL flush_exit mode=%0d current_out=%0d expected mode=0 current_out=0", mode, current_out);
        end
        spike_in = 4'b0;
    endtask

    task automatic test_run_write();
        go_run();
        wt_valid = 1'b1;
        wt_idx = 2'd0;
        wt_data = 8'd1;
        checks++;
        if (wt_ready !== 1'b0) begin
            failures++;
            $display("FAIL run_ready wt_ready=%b expected=0", wt_ready);
        end
        step();
        wt_valid = 1'b0;
        go_cfg();
        go_run();
        spike_in = 4'b0001;
        step();
        checks++;
        if (current_out !== 8'd200) begin
            failures++;
            $display("FAIL run_write_ignored current_out=%0d expected=200", current_out);
        end
        go_cfg();
    endtask

    task automatic test_reset_mid();
        do_reset();
        write_w(2'd0, 8'd20);
        write_w(2'd2, 8'd57);
        go_run();
        spike_in = 4'b0101;
        step();
        checks++;
        if (current_out !== 8'd77) begin
            failures++;
            $display("FAIL mid_setup current_out=%0d expected=77", current_out);
        end
        rst_n = 1'b1;
        start = 1'b1;
        step();
        rst_n = 1'b0;
        start = 1'b0;
        spike_in = 4'b0;
        checks++;
        if (current_out !== 8'd0 || mode !== 2'd0 || wt_ready !== 1'b1 || sat_flag !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset current_out=%0d mode=%0d ready=%b sat=%b expected 0,0,1,0", current_out, mode, wt_ready, sat_flag);
        end
        go_run();
        spike_in = 4'b0001;
        step();
        checks++;
        if (current_out !== 8'd8) begin
            failures++;
            $display("FAIL mid_w0_lost current_out=%0d expected=8", current_out);
        end
        spike_in = 4'b0100;
        step();
        checks++;
        if (current_out !== 8'd12) begin
            failures++;
            $display("FAIL mid_w2_lost current_out=%0d expected=12", current_out);
        end
        go_cfg();
    endtask

    initial begin
        rst_n = 1'b1;
        spike_in = 4'b0;
        start = 1'b0;
        stop = 1'b0;
        wt_valid = 1'b0;
        wt_idx = 2'd0;
        wt_data = 8'd0;
        test_reset();
        test_decay();
        test_steady();
        test_saturation();
        test_flush_simul();
        test_run_write();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
